fp_mac_seq: RTL
===============

# fp_mac_seq

Sequencer for the floating-point MAC datapath: software loads a vector length, an initial accumulator and a stream of operand pairs over the Avalon-MM slave port. The block queues the pairs in a small FIFO, issues one MAC operation per pair (result = A*B + C), and feeds each result back as the next C. It sits between the Avalon bus and a single MAC datapath instance, turning per-element bus traffic into one dot-product job with a done flag and interrupt.

## Interface
- FIFO_DEPTH, 8, operand-pair FIFO entries; power of two, 2..64
- LEN_W, 16, width of the length and remaining-count registers
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- address  in  3  Avalon register address
- writedata  in  32  Avalon write data
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- readdata  out  32  registered read data; 0 on reset
- mac_start  out  1  one-cycle issue pulse to datapath; 0 on reset
- mac_a, mac_b, mac_c  out  32 each  operands (A*B + C); 0 on reset
- mac_done  in  1  one-cycle completion pulse from datapath
- mac_result  in  32  result, valid when mac_done=1
- irq  out  1  level interrupt, set on job done; 0 on reset

## Operation
- Register map:
  - 0 CTRL (W): bit0 start, bit1 clear.
  - 1 LEN (R/W).
  - 2 ACC_INIT (R/W).
  - 3 PUSH_A (W): latches pending A.
  - 4 PUSH_B (W): pushes {pending A, writedata} into the FIFO.
  - 5 STATUS (R): bit0 busy, bit1 done, bit2 full, bit3 empty, bit4 overflow, bits[14:8] fifo count.
  - 6 RESULT (R): accumulator.
  - 7 REMAIN (R).
  - Writes to read-only addresses and reads of write-only addresses are ignored / return 0.
- FSM states:
  - IDLE: a start write loads acc=ACC_INIT and remain=LEN, clears done, and goes to WAIT_DATA. If LEN=0, it goes straight to DONE.
  - WAIT_DATA: if the FIFO is not empty, pop into the operand registers, go to ISSUE.
  - ISSUE: mac_start=1 for one cycle with mac_a/mac_b from the pair and mac_c=acc; go to WAIT_MAC.
  - WAIT_MAC: mac_a/b/c held stable. On mac_done: acc=mac_result, remain-=1; if remain becomes 0 go to DONE, else WAIT_DATA.
  - DONE: set done=1 and irq=1; go to IDLE.
- busy=1 in every state except IDLE.
- Start while busy is ignored. PUSH_A/PUSH_B are accepted in any state, so pairs may be preloaded before start.
- Reading RESULT clears done and irq. Done and irq are sticky until then, or until clear or reset.
- Clear (any state): state→IDLE, FIFO flushed, done/overflow/irq/remain cleared, acc and LEN kept. mac_done arriving outside WAIT_MAC is ignored, which covers a datapath still in flight after clear.
- No FP arithmetic is done in this block; values pass through bit-exact.

## Timing
- readdata is valid the cycle after the read strobe.
- Start at edge T: WAIT_DATA at T+1. With data present: pop at T+1, mac_start at T+2.
- Per element: 2 + L cycles, where L = cycles from mac_start to mac_done (L≥1).
- Done/irq assert 2 cycles after the final mac_done (DONE state, then registered flag). Busy drops the same cycle.
- FIFO boundaries:
  - Push when full (count evaluated before this cycle) is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Start and clear in the same write: clear wins.
- Reset mid-job: all state returns to reset values the next edge. mac_start never pulses twice for one pop.

## Test plan
- Dot product: MAC model L=3; LEN=2, ACC_INIT=0; pairs (0x3F800000,0x40000000), (0x40400000,0x3F000000); start. Expected: two mac_start pulses with mac_c=0x00000000, then 0x40000000; RESULT=0x40600000; irq=1; REMAIN=0.
- LEN=0 with ACC_INIT=0x3F800000, then start: done within 2 cycles, RESULT=0x3F800000, no mac_start.
- Push 9 pairs with FIFO_DEPTH=8 and no job running: STATUS full=1, overflow=1, count=8. The 9th pair is lost.
- Start with an empty FIFO and LEN=1: FSM idles in WAIT_DATA with no mac_start until the pair is pushed. Issue then follows 2 cycles after the PUSH_B write.
- Clear asserted during WAIT_MAC, then a late mac_done: state IDLE, acc unchanged, REMAIN=0, no irq.
- Second start while busy: ignored; REMAIN continues decrementing from its original value.

Source files
------------

// File: rtl/fp_mac_seq.sv
// Avalon-MM sequencer that streams queued operand pairs through one FP MAC
// datapath, chaining each result back as the next addend (dot product).
module fp_mac_seq #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    input  logic             write,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic             mac_start,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    output logic [31:0]      mac_c,
    input  logic             mac_done,
    input  logic [31:0]      mac_result,
    output logic             irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

    typedef enum logic [2:0] {IDLE, WAIT_DATA, ISSUE, WAIT_MAC, DONE} state_t;
    state_t state, state_nx;

    logic [LEN_W-1:0] len_q, remain;
    logic [31:0]      acc_init, acc, pend_a;
    logic [31:0]      fifo_a [FIFO_DEPTH];
    logic [31:0]      fifo_b [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             done, overflow, busy, full, empty;
    logic             ctrl_wr, clr, start, push, push_ok, pop, mac_ack, result_rd;

    assign ctrl_wr   = write && address == 3'd0;
    assign clr       = ctrl_wr && writedata[1];
    assign start     = ctrl_wr && writedata[0] && !writedata[1] && state == IDLE;
    assign push      = write && address == 3'd4;
    assign full      = count == FULL_CNT;
    assign empty     = count == '0;
    assign push_ok   = push && !full;
    assign pop       = state == WAIT_DATA && !empty && !clr;
    // A completion outside WAIT_MAC belongs to a job that was cleared.
    assign mac_ack   = state == WAIT_MAC && mac_done && !clr;
    assign result_rd = read && address == 3'd6;
    assign busy      = state != IDLE;
    assign mac_start = state == ISSUE;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start) state_nx = (len_q == '0) ? DONE : WAIT_DATA;
            WAIT_DATA: if (!empty) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_MAC;
            WAIT_MAC:  if (mac_done) state_nx = (remain == LEN_W'(1)) ? DONE : WAIT_DATA;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (clr) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_a[wr_ptr] <= pend_a;
            fifo_b[wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            remain   <= '0;
            acc_init <= '0;
            acc      <= '0;
            pend_a   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
            mac_a    <= '0;
            mac_b    <= '0;
            mac_c    <= '0;
            readdata <= '0;
        end else begin
            if (write && address == 3'd1) len_q <= writedata[LEN_W-1:0];
            if (write && address == 3'd2) acc_init <= writedata;
            if (write && address == 3'd3) pend_a <= writedata;
            if (start) begin
                acc    <= acc_init;
                remain <= len_q;
                done   <= 1'b0;
            end
            if (mac_ack) begin
                acc    <= mac_result;
                remain <= remain - LEN_W'(1);
            end
            if (pop) begin
                mac_a  <= fifo_a[rd_ptr];
                mac_b  <= fifo_b[rd_ptr];
                mac_c  <= acc;
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            if (push && full) overflow <= 1'b1;
            if (result_rd) begin
                done <= 1'b0;
                irq  <= 1'b0;
            end
            // A job finishing on the same edge as a RESULT read stays visible.
            if (state == DONE) begin
                done <= 1'b1;
                irq  <= 1'b1;
            end
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                done     <= 1'b0;
                overflow <= 1'b0;
                irq      <= 1'b0;
                remain   <= '0;
            end
            if (read) begin
                case (address)
                    3'd1:    readdata <= 32'(len_q);
                    3'd2:    readdata <= acc_init;
                    3'd5:    readdata <= {17'b0, 7'(count), 3'b0,
                                          overflow, empty, full, done, busy};
                    3'd6:    readdata <= acc;
                    3'd7:    readdata <= 32'(remain);
                    default: readdata <= '0;
                endcase
            end
        end
    end
endmodule
